// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response channel between the load/store stage (master) and memory (slave).
interface lsu_mem_stage_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [WIDTH-1:0]  mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_resp_valid;
  logic [WIDTH-1:0]  mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32 load/store stage: accepts one instruction from execute, issues an aligned word
// request to data memory, and registers a one-cycle writeback message.
module lsu_mem_stage #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [31:0]        ex_pc,
  input  logic [WIDTH-1:0]   ex_inst,
  input  logic [WIDTH-1:0]   ex_alu_result,
  input  logic [WIDTH-1:0]   ex_store_data,
  input  logic [1:0]         ex_mem_op,
  input  logic [1:0]         ex_size,
  input  logic               ex_load_unsigned,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               ex_ebreak,
  input  logic               ex_inst_valid,
  lsu_mem_stage_if.master    mem,
  output logic               wb_valid,
  output logic               wb_rf_we,
  output logic [4:0]         wb_rf_waddr,
  output logic [WIDTH-1:0]   wb_rf_wdata,
  output logic [WIDTH-1:0]   wb_dm_rdata,
  output logic [7:0]         wb_rmask,
  output logic [31:0]        wb_pc,
  output logic [WIDTH-1:0]   wb_inst,
  output logic               wb_ebreak,
  output logic               wb_inst_valid
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [WIDTH-1:0] inst;
    logic             rf_we;
    logic [4:0]       waddr;
    logic             ebreak;
    logic             ivalid;
    logic             is_load;
    logic [1:0]       size;
    logic             uns;
    logic [1:0]       off;
  } op_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [WIDTH-1:0]  wdata;
    logic [3:0]        wstrb;
  } req_t;

  typedef struct packed {
    logic             valid;
    logic             rf_we;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] dm_rdata;
    logic [7:0]       rmask;
    logic [31:0]      pc;
    logic [WIDTH-1:0] inst;
    logic             ebreak;
    logic             ivalid;
  } wb_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;
  req_t   req_q, req_d;
  wb_t    wb_q, wb_d;
  logic   ex_ready_q, ex_ready_d;

  logic              accept_s, is_mem_s, is_store_s, misaligned_s;
  logic [ADDR_W-1:0] ex_addr_s;
  logic [WIDTH-1:0]  st_data_s, shifted_s, load_data_s;
  logic [3:0]        st_strb_s;
  logic [7:0]        load_mask_s;

  assign ex_addr_s  = ex_alu_result[ADDR_W-1:0];
  assign accept_s   = ex_valid && ex_ready_q;
  assign is_store_s = (ex_mem_op == 2'b10);
  assign is_mem_s   = (ex_mem_op == 2'b01) || is_store_s;

  // Store lane replication, strobes and alignment check for the incoming instruction
  always_comb begin
    case (ex_size)
      2'b00: begin
        misaligned_s = 1'b0;
        st_data_s    = {(WIDTH/8){ex_store_data[7:0]}};
        st_strb_s    = 4'b0001 << ex_addr_s[1:0];
      end
      2'b01: begin
        misaligned_s = ex_addr_s[0];
        st_data_s    = {(WIDTH/16){ex_store_data[15:0]}};
        st_strb_s    = 4'b0011 << ex_addr_s[1:0];
      end
      default: begin
        misaligned_s = |ex_addr_s[1:0];
        st_data_s    = ex_store_data;
        st_strb_s    = 4'b1111;
      end
    endcase
  end

  // Extract the addressed lane of the returned word and extend it to register width
  always_comb begin
    shifted_s = mem.mem_resp_rdata >> {op_q.off, 3'b000};
    case (op_q.size)
      2'b00: begin
        load_data_s = {{(WIDTH-8){~op_q.uns & shifted_s[7]}}, shifted_s[7:0]};
        load_mask_s = 8'h01;
      end
      2'b01: begin
        load_data_s = {{(WIDTH-16){~op_q.uns & shifted_s[15]}}, shifted_s[15:0]};
        load_mask_s = 8'h03;
      end
      default: begin
        load_data_s = shifted_s;
        load_mask_s = 8'h0F;
      end
    endcase
  end

  // Next-state, request and writeback message computation
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    req_d       = req_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    wb_d.rf_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mem_s && !misaligned_s) begin
          op_d.pc      = ex_pc;
          op_d.inst    = ex_inst;
          op_d.rf_we   = ex_rf_we;
          op_d.waddr   = ex_rf_waddr;
          op_d.ebreak  = ex_ebreak;
          op_d.ivalid  = ex_inst_valid;
          op_d.is_load = !is_store_s;
          op_d.size    = ex_size;
          op_d.uns     = ex_load_unsigned;
          op_d.off     = ex_addr_s[1:0];
          req_d.valid  = 1'b1;
          req_d.addr   = {ex_addr_s[ADDR_W-1:2], 2'b00};
          req_d.wen    = is_store_s;
          req_d.wdata  = is_store_s ? st_data_s : {WIDTH{1'b0}};
          req_d.wstrb  = is_store_s ? st_strb_s : 4'b0000;
          state_d      = REQ;
        end else if (accept_s) begin
          // Misaligned memory ops retire like ALU ops but are flagged invalid
          wb_d.valid  = 1'b1;
          wb_d.rf_we  = ex_rf_we && !(is_mem_s && misaligned_s);
          wb_d.waddr  = ex_rf_waddr;
          wb_d.wdata  = ex_alu_result;
          wb_d.rmask  = 8'h00;
          wb_d.pc     = ex_pc;
          wb_d.inst   = ex_inst;
          wb_d.ebreak = ex_ebreak;
          wb_d.ivalid = ex_inst_valid && !(is_mem_s && misaligned_s);
          state_d     = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          req_d.valid = 1'b0;
          state_d     = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem.mem_resp_valid) begin
          wb_d.valid    = 1'b1;
          wb_d.rf_we    = op_q.is_load && op_q.rf_we;
          wb_d.waddr    = op_q.waddr;
          wb_d.wdata    = op_q.is_load ? load_data_s : {WIDTH{1'b0}};
          wb_d.dm_rdata = mem.mem_resp_rdata;
          wb_d.rmask    = op_q.is_load ? load_mask_s : 8'h00;
          wb_d.pc       = op_q.pc;
          wb_d.inst     = op_q.inst;
          wb_d.ebreak   = op_q.ebreak;
          wb_d.ivalid   = op_q.ivalid;
          state_d       = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        req_d.valid = 1'b0;
        state_d     = IDLE;
      end
    endcase
    ex_ready_d = (state_d == IDLE);
  end

  // State, latched instruction, request and writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      req_q      <= '0;
      wb_q       <= '0;
      ex_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      req_q      <= req_d;
      wb_q       <= wb_d;
      ex_ready_q <= ex_ready_d;
    end
  end

  assign ex_ready           = ex_ready_q;
  assign mem.mem_req_valid  = req_q.valid;
  assign mem.mem_req_addr   = req_q.addr;
  assign mem.mem_req_wen    = req_q.wen;
  assign mem.mem_req_wdata  = req_q.wdata;
  assign mem.mem_req_wstrb  = req_q.wstrb;
  assign wb_valid           = wb_q.valid;
  assign wb_rf_we           = wb_q.rf_we;
  assign wb_rf_waddr        = wb_q.waddr;
  assign wb_rf_wdata        = wb_q.wdata;
  assign wb_dm_rdata        = wb_q.dm_rdata;
  assign wb_rmask           = wb_q.rmask;
  assign wb_pc              = wb_q.pc;
  assign wb_inst            = wb_q.inst;
  assign wb_ebreak          = wb_q.ebreak;
  assign wb_inst_valid      = wb_q.ivalid;
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage between execute and writeback in the single-issue RV32 core.
- Takes one instruction per handshake from execute and issues aligned word requests to data memory through a valid/ready request and response interface.
- Lane-aligns store data and strobes, then extracts and sign/zero-extends load data.
- Registers the result into the one-cycle writeback message, which writeback always consumes.

Parameters:
- WIDTH, 32, datapath and register width
- ADDR_W, 32, memory address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ex_valid  in  1  execute holds a valid instruction
- ex_ready  out  1  stage can accept an instruction
- ex_pc  in  32  instruction PC
- ex_inst  in  WIDTH  instruction word
- ex_alu_result  in  WIDTH  effective address for memory ops; writeback data otherwise
- ex_store_data  in  WIDTH  rs2 value for stores
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_size  in  2  00 byte, 01 half, 10 word
- ex_load_unsigned  in  1  zero-extend load (LBU/LHU)
- ex_rf_we  in  1  instruction writes rd
- ex_rf_waddr  in  5  rd
- ex_ebreak  in  1  instruction is EBREAK
- ex_inst_valid  in  1  decoder recognised the instruction
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word-aligned address
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  WIDTH  lane-replicated store data
- mem_req_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  response (read data or write ack)
- mem_resp_rdata  in  WIDTH  read word
- wb_valid  out  1  writeback message valid this cycle
- wb_rf_we  out  1  register write enable (already gated by wb_valid)
- wb_rf_waddr  out  5  rd
- wb_rf_wdata  out  WIDTH  final register write data
- wb_dm_rdata  out  WIDTH  raw memory word (debug)
- wb_rmask  out  8  load byte mask: 8'h01/8'h03/8'h0F, 8'h00 for non-loads
- wb_pc  out  32  PC
- wb_inst  out  WIDTH  instruction
- wb_ebreak  out  1  EBREAK flag
- wb_inst_valid  out  1  instruction valid flag

Behaviour:
- FSM states: IDLE, REQ, WAIT. The FSM and all wb_* registers reset asynchronously on rst.
- Reset values: state IDLE; every wb_* output 0; mem_req_valid 0. The mem_req_addr/wdata/wstrb/wen registers reset to 0.
- ex_ready = (state == IDLE). An instruction is accepted when ex_valid && ex_ready; all ex_* fields are latched on acceptance.
- Non-memory op, accepted in IDLE:
  - Next cycle wb_valid=1 for exactly one cycle, with wb_rf_wdata = ex_alu_result and wb_rmask = 0. Latency 1.
  - State stays IDLE, so back-to-back accepts give one result per cycle.
- Misaligned memory op: half with addr[0]=1, or word with addr[1:0]!=0.
  - No memory request is issued; behaves as a non-memory op.
  - Forces wb_inst_valid=0 and wb_rf_we=0; ebreak, pc and inst pass through.
- Memory op, aligned:
  - IDLE -> REQ. In REQ, mem_req_valid=1 and all request fields are held stable until mem_req_ready.
  - REQ -> WAIT on the handshake cycle.
  - A response is accepted only in WAIT; mem_resp_valid in IDLE/REQ is ignored. Response latency to the stage is unbounded.
  - On mem_resp_valid in WAIT: register the writeback message, set wb_valid=1 for one cycle, and go to IDLE.
  - Minimum memory-op latency is 3 cycles (accept, req handshake, response).
- Request encoding:
  - mem_req_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Store wdata: byte replicated to all four lanes, half replicated to both halves, word as-is.
  - wstrb: 4'b0001 << addr[1:0] for byte, 4'b0011 << addr[1:0] for half, 4'b1111 for word.
  - Loads drive wstrb = 0 and wen = 0.
- Load data: shift rdata right by 8*addr[1:0], mask to size, then sign-extend unless ex_load_unsigned. wb_dm_rdata = raw rdata.
- Stores: after the write ack, wb_valid=1 with wb_rf_we=0, wb_rmask=0, and wb_rf_wdata=0.
- When wb_valid=0: wb_rf_we=0; the other wb_* outputs hold their last values.
- Reset mid-operation (REQ or WAIT): return to IDLE immediately, drop the pending instruction, deassert mem_req_valid; a late response is ignored.

Test Plan:
- Reset, then ALU op (alu_result=0x1234, rd=5, rf_we=1) -> 1 cycle later wb_valid=1, wb_rf_wdata=0x00001234, wb_rf_waddr=5, wb_rmask=0; back-to-back ALU ops give wb_valid on consecutive cycles.
- LB at addr 0x80000003, mem rdata=0x80FF0011 -> mem_req_addr=0x80000000, wstrb=0; wb_rf_wdata=0xFFFFFF80, wb_rmask=0x01. LBU same -> 0x00000080.
- SH data 0xABCD at addr 0x80000002, mem_req_ready low for 3 cycles -> request fields stable throughout, wdata=0xABCDABCD, wstrb=4'b1100; after ack wb_valid=1 with wb_rf_we=0.
- LW at addr 0x80000001 -> no mem_req_valid; next cycle wb_valid=1, wb_inst_valid=0, wb_rf_we=0.
- LW issued, rst pulsed while in WAIT, then mem_resp_valid arrives -> wb_valid stays 0, state IDLE, ex_ready=1.
- EBREAK (ex_ebreak=1, mem_op=none) -> wb_ebreak=1 with wb_valid=1 one cycle after accept.
